// File: rtl/ones_frame_accumulator.sv
// Frame accumulator for the 3-input ones counter: sums WORDS accepted
// 2-bit counts and reports the frame popcount with a one-cycle done pulse.
module ones_frame_accumulator #(
    parameter int WORDS = 8,
    parameter int SUM_W = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       cnt,
    output logic             in_ready,
    output logic             busy,
    output logic [IDX_W-1:0] idx,
    output logic [SUM_W-1:0] sum,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    localparam int IDX_MAX = (1 << IDX_W) - 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    // idx parks at WORDS, clipped when WORDS does not fit the field
    localparam logic [IDX_W-1:0] IDX_END =
        (WORDS > IDX_MAX) ? IDX_W'(IDX_MAX) : IDX_W'(WORDS);

    state_t           r_state;
    state_t           w_next;
    logic [SUM_W-1:0] r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == S_ACC) && in_valid;
    assign w_last   = (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_idx <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_sum <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + SUM_W'(cnt);
            r_idx <= w_last ? IDX_END : r_idx + 1'b1;
        end
    end

    assign sum = r_sum;
    assign idx = r_idx;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed self-checking bench for ones_frame_accumulator
// (WORDS=8, SUM_W=5, IDX_W=3, 50 ns clock).
module tb_ones_frame_accumulator;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [1:0] cnt;
    logic       in_ready;
    logic       busy;
    logic [2:0] idx;
    logic [4:0] sum;
    logic       done;

    int n_cmp;
    int n_bad;
    int done_cnt;
    int d0;
    int hits;
    int hit_at [2];
    logic [4:0] hit_sum [2];

    ones_frame_accumulator #(
        .WORDS(8),
        .SUM_W(5),
        .IDX_W(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .cnt     (cnt),
        .in_ready(in_ready),
        .busy    (busy),
        .idx     (idx),
        .sum     (sum),
        .done    (done)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [1:0] c, input int stalls);
        in_valid = 1'b1;
        cnt      = c;
        tick();
        in_valid = 1'b0;
        cnt      = 2'bxx;
        repeat (stalls) tick();
    endtask

    initial begin
        logic [1:0] seq3 [8];
        logic [1:0] seq4 [4];
        logic a, b, c;
        n_cmp    = 0;
        n_bad    = 0;
        done_cnt = 0;
        hits     = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        cnt      = 2'b00;
        seq3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        seq4 = '{2'd1, 2'd2, 2'd1, 2'd2};

        // reset state
        #60;
        check("rst_sum", 32'(sum), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();

        // 1: async reset mid-frame
        do_start();
        check("t1_ready", 32'(in_ready), 1);
        repeat (3) feed(2'd3, 0);
        check("t1_sum9", 32'(sum), 9);
        check("t1_idx3", 32'(idx), 3);
        #10 rst = 1'b1;
        #1;
        check("t1_rst_sum", 32'(sum), 0);
        check("t1_rst_idx", 32'(idx), 0);
        check("t1_rst_busy", 32'(busy), 0);
        #5 rst = 1'b0;
        repeat (3) tick();
        check("t1_no_done", 32'(done_cnt), 0);

        // 2: full-ones frame, idx saturates at 7
        do_start();
        for (int i = 0; i < 8; i++) feed(2'd3, 0);
        check("t2_done", 32'(done), 1);
        check("t2_sum", 32'(sum), 24);
        check("t2_idx", 32'(idx), 7);
        check("t2_busy", 32'(busy), 1);
        check("t2_ready", 32'(in_ready), 0);
        tick();
        check("t2_done_off", 32'(done), 0);
        check("t2_idle_busy", 32'(busy), 0);
        check("t2_hold_sum", 32'(sum), 24);
        tick();
        check("t2_hold_sum2", 32'(sum), 24);

        // 3: mixed values with stalls
        d0 = done_cnt;
        do_start();
        check("t3_restart_sum", 32'(sum), 0);
        for (int i = 0; i < 7; i++) begin
            feed(seq3[i], 1);
            check("t3_stall_ready", 32'(in_ready), 1);
            tick();
        end
        feed(seq3[7], 0);
        check("t3_done", 32'(done), 1);
        check("t3_sum", 32'(sum), 12);
        tick();
        tick();
        check("t3_one_done", 32'(done_cnt - d0), 1);

        // 4: start ignored during ACC
        do_start();
        for (int i = 0; i < 4; i++) feed(seq4[i], 0);
        do_start();
        check("t4_sum_kept", 32'(sum), 6);
        check("t4_idx_kept", 32'(idx), 4);
        check("t4_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) feed(2'd1, 0);
        check("t4_done", 32'(done), 1);
        check("t4_sum", 32'(sum), 10);
        tick();

        // 5: start held high, in_valid held high
        start    = 1'b1;
        in_valid = 1'b1;
        cnt      = 2'd2;
        tick();
        for (int n = 1; n <= 19; n++) begin
            tick();
            if (done && hits < 2) begin
                hit_at[hits]  = n;
                hit_sum[hits] = sum;
                hits++;
            end
            if (n == 9) check("t5_idle_gap", 32'(busy), 0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("t5_hits", 32'(hits), 2);
        if (hits == 2) begin
            check("t5_at1", 32'(hit_at[0]), 8);
            check("t5_at2", 32'(hit_at[1]), 18);
            check("t5_sum1", 32'(hit_sum[0]), 16);
            check("t5_sum2", 32'(hit_sum[1]), 16);
        end
        check("t5_end_idle", 32'(busy), 0);
        tick();
        check("t5_stays_idle", 32'(busy), 0);

        // 6: upstream counter through all a,b,c combinations
        do_start();
        for (int v = 0; v < 8; v++) begin
            {a, b, c} = 3'(v);
            feed({(a & b) | (a & c) | (b & c), a ^ b ^ c}, 0);
        end
        check("t6_done", 32'(done), 1);
        check("t6_sum", 32'(sum), 12);
        tick();
        check("t6_idle_sum", 32'(sum), 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
